// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback-port arbiter signals: the pipeline writeback
// request, the multi-cycle result handshake, the register-file write port
// and the status outputs. The slave modport is the arbiter's view.
interface wb_port_arbiter_if #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int WORD_BITWIDTH    = 32
);
  logic                        pipe_regWrite;
  logic [REG_NUM_BITWIDTH-1:0] pipe_regToWrite;
  logic [WORD_BITWIDTH-1:0]    pipe_regWriteData;
  logic                        mc_valid;
  logic [REG_NUM_BITWIDTH-1:0] mc_regToWrite;
  logic [WORD_BITWIDTH-1:0]    mc_data;
  logic                        mc_ready;
  logic                        rf_we;
  logic [REG_NUM_BITWIDTH-1:0] rf_waddr;
  logic [WORD_BITWIDTH-1:0]    rf_wdata;
  logic                        pipe_stall;
  logic                        pend_valid;

  modport slave (
    input  pipe_regWrite, pipe_regToWrite, pipe_regWriteData,
    input  mc_valid, mc_regToWrite, mc_data,
    output mc_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_valid
  );

  modport master (
    output pipe_regWrite, pipe_regToWrite, pipe_regWriteData,
    output mc_valid, mc_regToWrite, mc_data,
    input  mc_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_valid
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the writeback stage and a
// multi-cycle unit. The pipeline has priority; a colliding multi-cycle
// result is parked in a one-entry buffer and drained on the next free
// cycle, or forced out (stalling the pipeline) after STARVE_LIMIT blocked
// cycles. A younger pipeline write to the buffered register squashes it.
module wb_port_arbiter #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int WORD_BITWIDTH    = 32,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [CNT_W-1:0]            r_starve_cnt;
  logic [CNT_W-1:0]            w_next_starve_cnt;
  logic [REG_NUM_BITWIDTH-1:0] r_buf_reg;
  logic [REG_NUM_BITWIDTH-1:0] w_next_buf_reg;
  logic [WORD_BITWIDTH-1:0]    r_buf_data;
  logic [WORD_BITWIDTH-1:0]    w_next_buf_data;

  logic                        w_mc_ready;
  logic                        w_pipe_act;
  logic                        w_mc_act;
  logic                        w_rf_we;
  logic [REG_NUM_BITWIDTH-1:0] w_rf_waddr;
  logic [WORD_BITWIDTH-1:0]    w_rf_wdata;

  // Writes to register 0 are architecturally void, so they never count as active.
  assign w_mc_ready = (r_state == ST_IDLE) && !rst;
  assign w_pipe_act = bus.pipe_regWrite && (bus.pipe_regToWrite != {REG_NUM_BITWIDTH{1'b0}});
  assign w_mc_act   = bus.mc_valid && w_mc_ready &&
                      (bus.mc_regToWrite != {REG_NUM_BITWIDTH{1'b0}});

  // Next-state, buffer update and write-port selection.
  always_comb begin
    w_next_state      = r_state;
    w_next_starve_cnt = r_starve_cnt;
    w_next_buf_reg    = r_buf_reg;
    w_next_buf_data   = r_buf_data;
    w_rf_we           = 1'b0;
    w_rf_waddr        = {REG_NUM_BITWIDTH{1'b0}};
    w_rf_wdata        = {WORD_BITWIDTH{1'b0}};

    case (r_state)
      ST_IDLE: begin
        if (w_pipe_act) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = bus.pipe_regToWrite;
          w_rf_wdata = bus.pipe_regWriteData;
          if (w_mc_act) begin
            w_next_state      = ST_PEND;
            w_next_starve_cnt = {CNT_W{1'b0}};
            w_next_buf_reg    = bus.mc_regToWrite;
            w_next_buf_data   = bus.mc_data;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else if (w_mc_act) begin
          // Port is free: bypass the result straight to the register file.
          w_rf_we    = 1'b1;
          w_rf_waddr = bus.mc_regToWrite;
          w_rf_wdata = bus.mc_data;
        end else begin
          w_next_state = ST_IDLE;
        end
      end

      ST_PEND: begin
        if (!w_pipe_act) begin
          w_rf_we           = 1'b1;
          w_rf_waddr        = r_buf_reg;
          w_rf_wdata        = r_buf_data;
          w_next_state      = ST_IDLE;
          w_next_starve_cnt = {CNT_W{1'b0}};
          w_next_buf_reg    = {REG_NUM_BITWIDTH{1'b0}};
          w_next_buf_data   = {WORD_BITWIDTH{1'b0}};
        end else begin
          w_rf_we    = 1'b1;
          w_rf_waddr = bus.pipe_regToWrite;
          w_rf_wdata = bus.pipe_regWriteData;
          if (bus.pipe_regToWrite == r_buf_reg) begin
            // Younger pipeline write supersedes the parked result.
            w_next_state      = ST_IDLE;
            w_next_starve_cnt = {CNT_W{1'b0}};
            w_next_buf_reg    = {REG_NUM_BITWIDTH{1'b0}};
            w_next_buf_data   = {WORD_BITWIDTH{1'b0}};
          end else if (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
            w_next_state = ST_FORCE;
          end else begin
            w_next_starve_cnt = r_starve_cnt + CNT_W'(1);
          end
        end
      end

      ST_FORCE: begin
        // Upstream is held by pipe_stall, so the buffer owns the port.
        w_rf_we           = 1'b1;
        w_rf_waddr        = r_buf_reg;
        w_rf_wdata        = r_buf_data;
        w_next_state      = ST_IDLE;
        w_next_starve_cnt = {CNT_W{1'b0}};
        w_next_buf_reg    = {REG_NUM_BITWIDTH{1'b0}};
        w_next_buf_data   = {WORD_BITWIDTH{1'b0}};
      end

      default: begin
        w_next_state      = ST_IDLE;
        w_next_starve_cnt = {CNT_W{1'b0}};
        w_next_buf_reg    = {REG_NUM_BITWIDTH{1'b0}};
        w_next_buf_data   = {WORD_BITWIDTH{1'b0}};
      end
    endcase

    // Reset blocks any register-file write in the same cycle.
    if (rst) begin
      w_rf_we    = 1'b0;
      w_rf_waddr = {REG_NUM_BITWIDTH{1'b0}};
      w_rf_wdata = {WORD_BITWIDTH{1'b0}};
    end else begin
      w_rf_we = w_rf_we;
    end
  end

  // State, starvation counter and pending buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= {CNT_W{1'b0}};
      r_buf_reg    <= {REG_NUM_BITWIDTH{1'b0}};
      r_buf_data   <= {WORD_BITWIDTH{1'b0}};
    end else begin
      r_state      <= w_next_state;
      r_starve_cnt <= w_next_starve_cnt;
      r_buf_reg    <= w_next_buf_reg;
      r_buf_data   <= w_next_buf_data;
    end
  end

  assign bus.mc_ready   = w_mc_ready;
  assign bus.rf_we      = w_rf_we;
  assign bus.rf_waddr   = w_rf_waddr;
  assign bus.rf_wdata   = w_rf_wdata;
  assign bus.pipe_stall = (r_state == ST_FORCE);
  assign bus.pend_valid = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default parameters). Each step drives
// the inputs, pushes the expected port/status values onto a scoreboard and
// pops/compares them mid-cycle, before the next rising edge.
module tb_wb_port_arbiter;

  localparam int RW = 5;
  localparam int DW = 32;
  localparam int OBS_W = 1 + RW + DW + 3;

  typedef struct {
    string            tag;
    logic [OBS_W-1:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  wb_port_arbiter_if #(.REG_NUM_BITWIDTH(RW), .WORD_BITWIDTH(DW)) bus_if ();

  wb_port_arbiter #(
    .REG_NUM_BITWIDTH(RW),
    .WORD_BITWIDTH(DW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive, record expectation, compare at the falling edge, advance.
  task automatic step(
    input string           tag,
    input logic            r,
    input logic            pw,
    input logic [RW-1:0]   pr,
    input logic [DW-1:0]   pd,
    input logic            mv,
    input logic [RW-1:0]   mr,
    input logic [DW-1:0]   md,
    input logic            e_we,
    input logic [RW-1:0]   e_wa,
    input logic [DW-1:0]   e_wd,
    input logic            e_ready,
    input logic            e_stall,
    input logic            e_pend
  );
    exp_t             e;
    exp_t             got;
    logic [OBS_W-1:0] obs;
    rst                      = r;
    bus_if.pipe_regWrite     = pw;
    bus_if.pipe_regToWrite   = pr;
    bus_if.pipe_regWriteData = pd;
    bus_if.mc_valid          = mv;
    bus_if.mc_regToWrite     = mr;
    bus_if.mc_data           = md;
    e.tag = tag;
    e.val = {e_we, e_wa, e_wd, e_ready, e_stall, e_pend};
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    obs = {bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata,
           bus_if.mc_ready, bus_if.pipe_stall, bus_if.pend_valid};
    checks++;
    assert (obs === got.val) else begin
      errors++;
      $error("FAIL %s: observed we/addr/data/ready/stall/pend=%h expected %h",
             got.tag, obs, got.val);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.pipe_regWrite     = 1'b0;
    bus_if.pipe_regToWrite   = 5'd0;
    bus_if.pipe_regWriteData = 32'h0;
    bus_if.mc_valid          = 1'b0;
    bus_if.mc_regToWrite     = 5'd0;
    bus_if.mc_data           = 32'h0;
    @(posedge clk);
    #1;

    // Reset state, with an mc request that must not be accepted or written.
    step("reset_hold", 1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd7, 32'h1234,
         1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Bypass.
    step("bypass", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234,
         1'b1, 5'd7, 32'h1234, 1'b1, 1'b0, 1'b0);
    step("bypass_after", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
         1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Conflict then drain; the mc request during PEND is not accepted.
    step("conflict", 1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd5, 32'hB,
         1'b1, 5'd3, 32'hA, 1'b1, 1'b0, 1'b0);
    step("drain", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hC,
         1'b1, 5'd5, 32'hB, 1'b0, 1'b0, 1'b1);
    step("drain_after", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
         1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Starvation with STARVE_LIMIT=4.
    step("starve_cap", 1'b0, 1'b1, 5'd3, 32'h30, 1'b1, 5'd5, 32'h55,
         1'b1, 5'd3, 32'h30, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("starve_blk%0d", i), 1'b0, 1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 32'h0,
           1'b1, 5'(i), 32'(i * 16), 1'b0, 1'b0, 1'b1);
    end
    step("starve_force", 1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,
         1'b1, 5'd5, 32'h55, 1'b0, 1'b1, 1'b1);
    step("starve_release", 1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,
         1'b1, 5'd6, 32'h66, 1'b1, 1'b0, 1'b0);

    // Same-destination squash.
    step("squash_cap", 1'b0, 1'b1, 5'd2, 32'h20, 1'b1, 5'd9, 32'h11,
         1'b1, 5'd2, 32'h20, 1'b1, 1'b0, 1'b0);
    step("squash_hit", 1'b0, 1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'h0,
         1'b1, 5'd9, 32'h22, 1'b0, 1'b0, 1'b1);
    step("squash_idle1", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
         1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    step("squash_idle2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
         1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Register 0 from both sources.
    step("reg0_both", 1'b0, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE,
         1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    step("reg0_after", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
         1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Pipeline reg-0 write while pending counts as inactive: buffer drains.
    step("p0_cap", 1'b0, 1'b1, 5'd4, 32'h40, 1'b1, 5'd8, 32'h88,
         1'b1, 5'd4, 32'h40, 1'b1, 1'b0, 1'b0);
    step("p0_drain", 1'b0, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0,
         1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 1'b1);

    // Reset mid-operation with starve_cnt at 2.
    step("rmid_cap", 1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hCC,
         1'b1, 5'd1, 32'h1, 1'b1, 1'b0, 1'b0);
    step("rmid_blk1", 1'b0, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0,
         1'b1, 5'd2, 32'h2, 1'b0, 1'b0, 1'b1);
    step("rmid_blk2", 1'b0, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0,
         1'b1, 5'd3, 32'h3, 1'b0, 1'b0, 1'b1);
    step("rmid_rst", 1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd13, 32'hDD,
         1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    step("rmid_post1", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
         1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    step("rmid_post2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
         1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Port still works after the mid-operation reset.
    step("post_bypass", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hDEADBEEF,
         1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
